// File: rtl/sar_avg_decim.sv
// Boxcar decimator for SAR results: averages 2^LOG2_N captures and offers them on valid/ready.
// Optional round-half-up averaging is enabled by defining SAR_AVG_ROUND_EN.
module sar_avg_decim #(
   parameter int unsigned DATA_W = 12,
   parameter int unsigned LOG2_N = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              conv_done,
   input  logic              clr,
   output logic [DATA_W-1:0] avg_out,
   output logic              avg_valid,
   input  logic              avg_ready,
   output logic              overrun,
   output logic [LOG2_N:0]   fill_cnt
);

   localparam int unsigned ACC_W = DATA_W + LOG2_N + 1;
   localparam int unsigned CNT_W = LOG2_N + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_N) - 1);

   logic [ACC_W-1:0]  acc_q;
   logic [ACC_W-1:0]  sum;
   logic [DATA_W-1:0] result;
   logic              conv_done_q;
   logic              cap;
   logic              last;
   logic              can_load;

   // One capture per rising edge of conv_done, however long it stays high.
   assign cap      = conv_done & ~conv_done_q;
   assign last     = (fill_cnt == LAST_CNT);
   assign sum      = acc_q + ACC_W'(sample_in);
   assign can_load = ~avg_valid | avg_ready;

`ifdef SAR_AVG_ROUND_EN
   // Half an LSB of the output; zero when LOG2_N is 0.
   localparam logic [ACC_W-1:0] HALF = ACC_W'((1 << LOG2_N) >> 1);
   assign result = DATA_W'((sum + HALF) >> LOG2_N);
`else
   assign result = DATA_W'(sum >> LOG2_N);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         fill_cnt    <= '0;
         avg_out     <= '0;
         avg_valid   <= 1'b0;
         overrun     <= 1'b0;
         conv_done_q <= 1'b0;
      end else begin
         conv_done_q <= conv_done;
         if (clr) begin
            acc_q     <= '0;
            fill_cnt  <= '0;
            avg_valid <= 1'b0;
            overrun   <= 1'b0;
         end else begin
            if (avg_valid && avg_ready) begin
               avg_valid <= 1'b0;
            end
            if (cap) begin
               if (!last) begin
                  acc_q    <= sum;
                  fill_cnt <= fill_cnt + CNT_W'(1);
               end else begin
                  acc_q    <= '0;
                  fill_cnt <= '0;
                  // A full window that cannot be handed over is dropped and flagged.
                  if (can_load) begin
                     avg_out   <= result;
                     avg_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sar_avg_decim.sv
// Bench for sar_avg_decim: directed scenarios plus random traffic against a window-list model.
// Build with SAR_AVG_ROUND_EN defined to exercise the rounding variant.
module tb_sar_avg_decim;

   localparam int unsigned DATA_W = 12;
   localparam int unsigned LOG2_N = 2;
   localparam int N = 1 << LOG2_N;
`ifdef SAR_AVG_ROUND_EN
   localparam int EXP_SMALL = 2;
`else
   localparam int EXP_SMALL = 1;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] sample_in = '0;
   logic              conv_done = 1'b0;
   logic              clr = 1'b0;
   logic              avg_ready = 1'b0;
   logic [DATA_W-1:0] avg_out;
   logic              avg_valid;
   logic              overrun;
   logic [LOG2_N:0]   fill_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state
   int m_win[$];
   int m_out   = 0;
   bit m_valid = 0;
   bit m_ovr   = 0;
   bit m_prev  = 0;

   sar_avg_decim #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_in (sample_in),
      .conv_done (conv_done),
      .clr       (clr),
      .avg_out   (avg_out),
      .avg_valid (avg_valid),
      .avg_ready (avg_ready),
      .overrun   (overrun),
      .fill_cnt  (fill_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int window_avg();
      int s = 0;
      foreach (m_win[i]) s += m_win[i];
`ifdef SAR_AVG_ROUND_EN
      s += N / 2;
`endif
      return s / N;
   endfunction

   function automatic void model_reset();
      m_win.delete();
      m_out   = 0;
      m_valid = 0;
      m_ovr   = 0;
      m_prev  = 0;
   endfunction

   // Applies the inputs present at a rising edge to the model.
   function automatic void model_edge();
      bit cap;
      bit old_valid;
      if (!rst_n) begin
         model_reset();
         return;
      end
      cap    = conv_done && !m_prev;
      m_prev = conv_done;
      if (clr) begin
         m_win.delete();
         m_valid = 0;
         m_ovr   = 0;
         return;
      end
      old_valid = m_valid;
      if (m_valid && avg_ready) m_valid = 0;
      if (cap) begin
         m_win.push_back(int'(sample_in));
         if (m_win.size() == N) begin
            if (!old_valid || avg_ready) begin
               m_out   = window_avg();
               m_valid = 1;
            end else begin
               m_ovr = 1;
            end
            m_win.delete();
         end
      end
   endfunction

   task automatic check_model(input string tag);
      check({tag, ".avg_out"},   32'(avg_out),   32'(m_out));
      check({tag, ".avg_valid"}, 32'(avg_valid), 32'(m_valid));
      check({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
      check({tag, ".fill_cnt"},  32'(fill_cnt),  32'(m_win.size()));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_model(tag);
   endtask

   task automatic pulse(input int value, input string tag);
      sample_in = DATA_W'(value);
      conv_done = 1'b1;
      step(tag);
      conv_done = 1'b0;
      step(tag);
   endtask

   task automatic drain();
      avg_ready = 1'b1;
      step("drain");
      avg_ready = 1'b0;
   endtask

   initial begin
      model_reset();
      #2;
      check_model("reset");
      step("reset_hold");
      #1 rst_n = 1'b1;
      step("post_reset");

      // Basic average
      pulse(100, "basic"); pulse(200, "basic"); pulse(300, "basic"); pulse(400, "basic");
      check("basic_avg", 32'(avg_out), 32'd250);
      check("basic_valid", 32'(avg_valid), 32'd1);
      avg_ready = 1'b1;
      step("basic_hs");
      avg_ready = 1'b0;
      check("basic_valid_drop", 32'(avg_valid), 32'd0);

      // Truncation versus rounding
      pulse(1, "small"); pulse(2, "small"); pulse(2, "small"); pulse(2, "small");
      check("small_avg", 32'(avg_out), 32'(EXP_SMALL));
      drain();
      for (int i = 0; i < N; i++) pulse(4095, "full");
      check("full_avg", 32'(avg_out), 32'd4095);
      drain();

      // Long conv_done high counts once
      sample_in = DATA_W'(50);
      conv_done = 1'b1;
      for (int i = 0; i < 10; i++) step("long_high");
      check("long_fill1", 32'(fill_cnt), 32'd1);
      conv_done = 1'b0;
      step("long_low");
      pulse(50, "long"); check("long_fill2", 32'(fill_cnt), 32'd2);
      pulse(50, "long"); check("long_fill3", 32'(fill_cnt), 32'd3);
      pulse(50, "long"); check("long_fill0", 32'(fill_cnt), 32'd0);
      check("long_avg", 32'(avg_out), 32'd50);
      check("long_valid", 32'(avg_valid), 32'd1);
      drain();

      // Overrun
      for (int i = 0; i < N; i++) pulse(10, "ovr_a");
      for (int i = 0; i < N; i++) pulse(20, "ovr_b");
      check("ovr_hold", 32'(avg_out), 32'd10);
      check("ovr_flag", 32'(overrun), 32'd1);
      avg_ready = 1'b1;
      step("ovr_hs");
      avg_ready = 1'b0;
      check("ovr_sticky", 32'(overrun), 32'd1);
      check("ovr_valid0", 32'(avg_valid), 32'd0);
      clr = 1'b1;
      step("ovr_clr");
      clr = 1'b0;
      check("clr_ovr", 32'(overrun), 32'd0);
      check("clr_valid", 32'(avg_valid), 32'd0);

      // Completion coincides with a handshake
      for (int i = 0; i < N; i++) pulse(40, "same_a");
      for (int i = 0; i < N - 1; i++) pulse(80, "same_b");
      avg_ready = 1'b1;
      sample_in = DATA_W'(80);
      conv_done = 1'b1;
      step("same_edge");
      avg_ready = 1'b0;
      conv_done = 1'b0;
      check("same_out", 32'(avg_out), 32'd80);
      check("same_valid", 32'(avg_valid), 32'd1);
      check("same_ovr", 32'(overrun), 32'd0);
      step("same_tail");
      drain();

      // Asynchronous reset mid-window
      pulse(300, "mid"); pulse(300, "mid");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_out", 32'(avg_out), 32'd0);
      check("arst_fill", 32'(fill_cnt), 32'd0);
      check("arst_valid", 32'(avg_valid), 32'd0);
      #1 rst_n = 1'b1;
      for (int i = 0; i < N; i++) pulse(8, "after_rst");
      check("after_rst_avg", 32'(avg_out), 32'd8);
      drain();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         if (!conv_done) sample_in = DATA_W'($urandom_range(0, 4095));
         conv_done = ($urandom_range(0, 2) == 0);
         avg_ready = ($urandom_range(0, 3) == 0);
         clr       = ($urandom_range(0, 59) == 0);
         step("rand");
      end
      clr = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
